// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS memory-stage data-bus initiator with load alignment and address-error detection
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        m_flush,
    input  logic        m_advance,
    output logic        dbus_valid,
    output logic [31:0] dbus_addr,
    output logic [1:0]  dbus_size,
    output logic [3:0]  dbus_strobe,
    output logic [31:0] dbus_data,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] load_data,
    output logic        stall_mem,
    output logic        adel,
    output logic        ades
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] hold;
    logic        op;
    logic        misaligned;
    logic        need;
    logic        issue;
    logic        live;
    logic [3:0]  strobe_w;
    logic [31:0] data_w;
    logic [31:0] shifted;
    logic [31:0] extracted;

    assign op         = mem_read | mem_write;
    assign misaligned = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
    assign need       = op & ~misaligned;
    assign issue      = need & ~m_flush;
    assign live       = (state == S_IDLE) | (state == S_REQ) | (state == S_WAIT);

    assign adel      = mem_read & misaligned;
    assign ades      = mem_write & misaligned;
    assign dbus_addr = addr;
    assign dbus_size = size;

    always_comb begin
        strobe_w = 4'b1111;
        data_w   = wdata;
        case (size)
            2'd0: begin
                strobe_w = 4'b0001 << addr[1:0];
                data_w   = {4{wdata[7:0]}};
            end
            2'd1: begin
                strobe_w = 4'b0011 << {addr[1], 1'b0};
                data_w   = {2{wdata[15:0]}};
            end
            default: begin
                strobe_w = 4'b1111;
                data_w   = wdata;
            end
        endcase
    end

    assign dbus_strobe = mem_write ? strobe_w : 4'b0000;
    assign dbus_data   = data_w;

    always_comb begin
        shifted   = dbus_rdata >> {addr[1:0], 3'b000};
        extracted = shifted;
        case (size)
            2'd0:    extracted = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            2'd1:    extracted = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    if (dbus_addr_ok) begin
                        state_n = dbus_data_ok ? (m_advance ? S_IDLE : S_DONE) : S_WAIT;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An accepted request cannot be withdrawn; a flush then has to drain its response.
                if (dbus_addr_ok) begin
                    if (m_flush) begin
                        state_n = dbus_data_ok ? S_IDLE : S_DRAIN;
                    end else begin
                        state_n = dbus_data_ok ? (m_advance ? S_IDLE : S_DONE) : S_WAIT;
                    end
                end else if (m_flush) begin
                    state_n = S_IDLE;
                end
            end
            S_WAIT: begin
                if (dbus_data_ok) begin
                    state_n = (m_advance | m_flush) ? S_IDLE : S_DONE;
                end else if (m_flush) begin
                    state_n = S_DRAIN;
                end
            end
            S_DONE: begin
                if (m_advance | m_flush) begin
                    state_n = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dbus_data_ok) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        dbus_valid = 1'b0;
        stall_mem  = 1'b0;
        load_data  = 32'h0;
        case (state)
            S_IDLE: begin
                dbus_valid = issue;
                stall_mem  = need & ~dbus_data_ok;
                load_data  = dbus_data_ok ? extracted : 32'h0;
            end
            S_REQ: begin
                dbus_valid = 1'b1;
                stall_mem  = need & ~dbus_data_ok;
                load_data  = dbus_data_ok ? extracted : 32'h0;
            end
            S_WAIT: begin
                stall_mem = need & ~dbus_data_ok;
                load_data = dbus_data_ok ? extracted : 32'h0;
            end
            S_DONE: begin
                load_data = hold;
            end
            S_DRAIN: begin
                stall_mem = op;
            end
            default: begin
                dbus_valid = 1'b0;
            end
        endcase
    end

    // Keeps the result while other stall sources block the M/W register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold <= 32'h0;
        end else if (dbus_data_ok && live) begin
            hold <= extracted;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        is_signed = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        m_flush = 1'b0;
    logic        m_advance = 1'b0;
    logic        dbus_valid;
    logic [31:0] dbus_addr;
    logic [1:0]  dbus_size;
    logic [3:0]  dbus_strobe;
    logic [31:0] dbus_data;
    logic        dbus_addr_ok = 1'b0;
    logic        dbus_data_ok = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
    logic [31:0] load_data;
    logic        stall_mem;
    logic        adel;
    logic        ades;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .size         (size),
        .is_signed    (is_signed),
        .addr         (addr),
        .wdata        (wdata),
        .m_flush      (m_flush),
        .m_advance    (m_advance),
        .dbus_valid   (dbus_valid),
        .dbus_addr    (dbus_addr),
        .dbus_size    (dbus_size),
        .dbus_strobe  (dbus_strobe),
        .dbus_data    (dbus_data),
        .dbus_addr_ok (dbus_addr_ok),
        .dbus_data_ok (dbus_data_ok),
        .dbus_rdata   (dbus_rdata),
        .load_data    (load_data),
        .stall_mem    (stall_mem),
        .adel         (adel),
        .ades         (ades)
    );

    typedef struct {
        string       name;
        logic        rstn;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        flush;
        logic        adv;
        logic        aok;
        logic        dok;
        logic [31:0] rdat;
        logic        e_valid;
        logic        e_stall;
        logic        e_adel;
        logic        e_ades;
        logic        chk_bus;
        logic [3:0]  e_strobe;
        logic [31:0] e_data;
        logic        chk_load;
        logic [31:0] e_load;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(string name, logic rd, logic wr, logic [1:0] sz, logic sg,
                                logic [31:0] a, logic [31:0] wd, logic flush, logic adv,
                                logic aok, logic dok, logic [31:0] rdat,
                                logic e_valid, logic e_stall, logic e_adel, logic e_ades,
                                logic chk_bus, logic [3:0] e_strobe, logic [31:0] e_data,
                                logic chk_load, logic [31:0] e_load);
        vec_t v;
        v.name = name; v.rstn = 1'b1; v.rd = rd; v.wr = wr; v.sz = sz; v.sg = sg;
        v.a = a; v.wd = wd; v.flush = flush; v.adv = adv; v.aok = aok; v.dok = dok;
        v.rdat = rdat; v.e_valid = e_valid; v.e_stall = e_stall; v.e_adel = e_adel;
        v.e_ades = e_ades; v.chk_bus = chk_bus; v.e_strobe = e_strobe; v.e_data = e_data;
        v.chk_load = chk_load; v.e_load = e_load;
        return v;
    endfunction

    task automatic cmp(string name, string what, logic [31:0] got, logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s %s: got %h want %h", name, what, got, want);
        end
    endtask

    task automatic check_out();
        vec_t e;
        e = exp_q.pop_front();
        cmp(e.name, "dbus_valid", {31'd0, dbus_valid}, {31'd0, e.e_valid});
        cmp(e.name, "stall_mem", {31'd0, stall_mem}, {31'd0, e.e_stall});
        cmp(e.name, "adel", {31'd0, adel}, {31'd0, e.e_adel});
        cmp(e.name, "ades", {31'd0, ades}, {31'd0, e.e_ades});
        if (e.chk_bus) begin
            cmp(e.name, "dbus_strobe", {28'd0, dbus_strobe}, {28'd0, e.e_strobe});
            cmp(e.name, "dbus_data", dbus_data, e.e_data);
            cmp(e.name, "dbus_addr", dbus_addr, e.a);
            cmp(e.name, "dbus_size", {30'd0, dbus_size}, {30'd0, e.sz});
        end
        if (e.chk_load) begin
            cmp(e.name, "load_data", load_data, e.e_load);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        resetn = v.rstn; mem_read = v.rd; mem_write = v.wr; size = v.sz; is_signed = v.sg;
        addr = v.a; wdata = v.wd; m_flush = v.flush; m_advance = v.adv;
        dbus_addr_ok = v.aok; dbus_data_ok = v.dok; dbus_rdata = v.rdat;
        exp_q.push_back(v);
        applied++;
        @(negedge clk);
        check_out();
    endtask

    function automatic vec_t idle_vec(string name);
        return mk(name, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0,
                  0, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'h0);
    endfunction

    initial begin
        vec_t v;

        // single-cycle accesses: addr_ok and data_ok in the issue cycle, M/W advancing
        tbl.push_back(idle_vec("reset_state"));
        tbl.push_back(mk("lb_signed_a3", 1, 0, 2'd0, 1, 32'h1000_0003, 32'h0, 0, 1, 1, 1, 32'h80FF_FFFF,
                         1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'hFFFF_FF80));
        tbl.push_back(mk("lhu_a2", 1, 0, 2'd1, 0, 32'h1000_0002, 32'h0, 0, 1, 1, 1, 32'hBEEF_0000,
                         1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'h0000_BEEF));
        tbl.push_back(mk("lh_signed_a0", 1, 0, 2'd1, 1, 32'h1000_0000, 32'h0, 0, 1, 1, 1, 32'h0000_8001,
                         1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'hFFFF_8001));
        tbl.push_back(mk("lbu_a1", 1, 0, 2'd0, 0, 32'h1000_0001, 32'h0, 0, 1, 1, 1, 32'h0000_C300,
                         1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'h0000_00C3));
        tbl.push_back(mk("lw_a8", 1, 0, 2'd2, 0, 32'h1000_0008, 32'h0, 0, 1, 1, 1, 32'hCAFE_F00D,
                         1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'hCAFE_F00D));
        tbl.push_back(mk("sb_a1", 0, 1, 2'd0, 0, 32'h2000_0001, 32'h0000_00AB, 0, 1, 1, 1, 32'h0,
                         1, 0, 0, 0, 1, 4'b0010, 32'hABAB_ABAB, 0, 32'h0));
        tbl.push_back(mk("sh_a2", 0, 1, 2'd1, 0, 32'h2000_0002, 32'h0000_1234, 0, 1, 1, 1, 32'h0,
                         1, 0, 0, 0, 1, 4'b1100, 32'h1234_1234, 0, 32'h0));
        tbl.push_back(mk("sw_a4", 0, 1, 2'd2, 0, 32'h2000_0004, 32'hDEAD_BEEF, 0, 1, 1, 1, 32'h0,
                         1, 0, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0));
        tbl.push_back(mk("sb_a3", 0, 1, 2'd0, 0, 32'h2000_0003, 32'h0000_005A, 0, 1, 1, 1, 32'h0,
                         1, 0, 0, 0, 1, 4'b1000, 32'h5A5A_5A5A, 0, 32'h0));
        tbl.push_back(mk("lw_misalign_a2", 1, 0, 2'd2, 0, 32'h1000_0002, 32'h0, 0, 1, 0, 0, 32'h0,
                         0, 0, 1, 0, 0, 4'b0000, 32'h0, 1, 32'h0));
        tbl.push_back(mk("sh_misalign_a1", 0, 1, 2'd1, 0, 32'h2000_0001, 32'h0, 0, 1, 0, 0, 32'h0,
                         0, 0, 0, 1, 0, 4'b0000, 32'h0, 0, 32'h0));
        tbl.push_back(mk("lh_misalign_a3", 1, 0, 2'd1, 1, 32'h1000_0003, 32'h0, 0, 1, 0, 0, 32'h0,
                         0, 0, 1, 0, 0, 4'b0000, 32'h0, 1, 32'h0));
        tbl.push_back(mk("sw_misalign_a1", 0, 1, 2'd2, 0, 32'h2000_0001, 32'h0, 0, 1, 0, 0, 32'h0,
                         0, 0, 0, 1, 0, 4'b0000, 32'h0, 0, 32'h0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // word load, addr_ok in issue cycle, data_ok two cycles later
        step(mk("lat_c0", 1, 0, 2'd2, 0, 32'h8000_0004, 32'h0, 0, 0, 1, 0, 32'h0,
                1, 1, 0, 0, 1, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("lat_c1", 1, 0, 2'd2, 0, 32'h8000_0004, 32'h0, 0, 0, 0, 0, 32'h0,
                0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("lat_c2", 1, 0, 2'd2, 0, 32'h8000_0004, 32'h0, 0, 1, 0, 1, 32'h1234_5678,
                0, 0, 0, 0, 0, 4'b0000, 32'h0, 1, 32'h1234_5678));
        step(idle_vec("lat_c3"));

        // REQ, then completion while M/W is held: result must persist in DONE
        step(mk("hold_c0", 1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 0, 0, 0, 0, 32'h0,
                1, 1, 0, 0, 1, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("hold_c1", 1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 0, 0, 1, 1, 32'h0BAD_F00D,
                1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'h0BAD_F00D));
        for (int k = 0; k < 3; k++) begin
            step(mk("hold_done", 1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 0, 0, 0, 0, 32'hFFFF_FFFF,
                    0, 0, 0, 0, 0, 4'b0000, 32'h0, 1, 32'h0BAD_F00D));
        end
        step(mk("hold_release", 1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 0, 1, 0, 0, 32'hFFFF_FFFF,
                0, 0, 0, 0, 0, 4'b0000, 32'h0, 1, 32'h0BAD_F00D));
        step(idle_vec("hold_idle"));

        // flush in WAIT, new load waits in DRAIN for the stale response
        step(mk("drain_c0", 1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 0, 0, 1, 0, 32'h0,
                1, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("drain_flush", 1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 1, 0, 0, 0, 32'h0,
                0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("drain_wait", 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 0, 0, 0, 0, 32'h0,
                0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0));
        step(mk("drain_stale", 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 0, 0, 0, 1, 32'h1111_1111,
                0, 1, 0, 0, 0, 4'b0000, 32'h0, 1, 32'h0));
        step(mk("drain_fresh", 1, 0, 2'd2, 0, 32'h0000_0300, 32'h0, 0, 1, 1, 1, 32'h2222_2222,
                1, 0, 0, 0, 1, 4'b0000, 32'h0, 1, 32'h2222_2222));
        step(idle_vec("drain_idle"));

        // synchronous reset while a request is pending in REQ
        step(mk("rst_c0", 1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 0, 0, 0, 0, 32'h0,
                1, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0));
        v = mk("rst_assert", 1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 0, 0, 0, 0, 32'h0,
               1, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 32'h0);
        v.rstn = 1'b0;
        step(v);
        step(mk("rst_idle", 1, 0, 2'd2, 0, 32'h0000_0400, 32'h0, 1, 0, 0, 0, 32'h0,
                0, 1, 0, 0, 0, 4'b0000, 32'h0, 1, 32'h0));
        step(idle_vec("rst_after"));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
